irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Parametrised 68000 interrupt controller; generalises the fixed 3-input VBlank/HDMI/user IRQ logic of the system top.
//  Routes NUM_SRC async sources to NUM_CH channels: per-channel invert, edge/level mode, enable and IPL priority.
//  Drives fx68k IPL2n..IPL0n and clears pending on the IACK cycle; CPU-mapped like the other 16-bit peripherals.
// PARAMETERS
//  NUM_CH   3  interrupt channels, 1..8
//  NUM_SRC  4  source inputs, 1..7; CFG.SRC=0 selects constant 0, SRC=k selects src[k-1]
//  SYNC_FF  2  synchroniser depth per source, >=2
// PORTS
//  clk      in   1        system clock
//  reset_n  in   1        asynchronous, active-low reset
//  cs       in   1        register select
//  wr       in   2        byte write strobes {upper,lower}; 00 = read
//  address  in   6        word address
//  din      in   16       write data
//  dout     out  16       read data, combinational from address
//  src      in   NUM_SRC  raw async interrupt sources
//  ack      in   1        1-cycle IACK pulse (FC=111 & ~AS)
//  ipl_n    out  3        active-low IPL to CPU
//  ticks    in   32       free-running timestamp (used only with IRQ_TIMESTAMP_EN)
// BEHAVIOUR
//  Registers (word addr): 0x00+ch CFG[ch]: [2:0]SRC [3]INV [4]LEVEL [5]EN [10:8]IPL; others RAZ/WI.
//   0x10 PENDING R, write-1-to-clear [NUM_CH-1:0]; 0x11 STATUS R {[7:4]active_ch,[2:0]cur_ipl}.
//  Reset: all CFG=0, pending=0, ipl_n=3'b111, active_ch=0, sync/prev flops=0; dout follows map.
//  Input path: src -> SYNC_FF flops -> select -> XOR INV = sig[ch]; prev[ch] registered sig.
//  Edge mode (LEVEL=0): sig & ~prev sets pending; held until ack or W1C.
//  Level mode (LEVEL=1): pending = sig each cycle; ack/W1C no effect while sig high.
//  Arbitration (1 cycle reg): cand = pending & EN & IPL!=0; winner = max IPL, tie -> lowest ch.
//   States IDLE -> ASSERT (ipl_n=~winner.IPL, latch active_ch) -> ack -> HOLD (ipl_n=111, 1 cycle) -> IDLE.
//   ASSERT holds IPL fixed until ack even if higher channel arrives (re-arbitrated after HOLD).
//   ASSERT with cand empty (W1C/disable) -> IDLE, ipl_n=111 next cycle.
//  ack in ASSERT clears pending[active_ch] if edge mode; ack in IDLE/HOLD ignored.
//  Simultaneous set and clear (ack or W1C) same cycle same channel: set wins.
//  EN=0 masks arbitration only; pending still sets and is readable.
//  CFG writes take effect next cycle; byte strobes honoured per byte.
//  Reset mid-operation: immediate async return to reset values; no spurious edge after release.
// CONFIGURATION
//  IRQ_TIMESTAMP_EN defined: per channel, ticks latched into TS[ch] when pending sets from 0 (edge mode);
//   read TS hi at 0x20+2ch, lo at 0x21+2ch; reset 0.
//  Undefined: TS logic absent, 0x20..0x2F read 0, ticks unused.
// STRUCTURE
//  irq_ctrl_pkg: register offsets, CFG field positions, typedef struct packed irq_cfg_t, state enum.
//  Sub-module irq_sync_edge: SYNC_FF synchroniser + prev flop; one instance per source.
// TESTING
//  1 CH0 SRC=1 EN IPL=1 edge, pulse src[0] 3 cycles -> PENDING=1, ipl_n=110 within SYNC_FF+3 cycles; ack -> PENDING=0, ipl_n=111.
//  2 CH0 IPL=1, CH2 IPL=3 pend same cycle -> ipl_n=100, STATUS=0x23; after ack+HOLD -> ipl_n=110.
//  3 CH1 level mode, src high: W1C 0x0002 -> PENDING stays 2; src low -> PENDING=0, ipl_n=111.
//  4 edge set and W1C in same cycle on CH0 -> PENDING bit0=1.
//  5 EN=0, edge -> PENDING=1, ipl_n=111; set EN -> ipl_n asserts 2 cycles later.
//  6 IRQ_TIMESTAMP_EN, ticks=0x12345678 at edge -> TS0 hi=0x1234 lo=0x5678; reset_n low mid-ASSERT -> ipl_n=111 immediately.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the 68000 interrupt controller.
//   - register word addresses (PENDING, STATUS, timestamp window)
//   - CFG field positions and the packed per-channel configuration struct
//   - arbitration/IPL state encoding
//   - cfg_to_word: packs a channel configuration into its register image
// Optional feature macro used by the controller: IRQ_TIMESTAMP_EN.
package irq_ctrl_pkg;

   localparam logic [5:0] ADDR_PENDING = 6'h10;
   localparam logic [5:0] ADDR_STATUS  = 6'h11;
   localparam logic [5:0] ADDR_TS_BASE = 6'h20;

   localparam int CFG_SRC_LSB   = 0;
   localparam int CFG_INV_BIT   = 3;
   localparam int CFG_LEVEL_BIT = 4;
   localparam int CFG_EN_BIT    = 5;
   localparam int CFG_IPL_LSB   = 8;

   typedef struct packed {
      logic [2:0] ipl;
      logic       en;
      logic       level;
      logic       inv;
      logic [2:0] src;
   } irq_cfg_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2
   } irq_state_e;

   function automatic logic [15:0] cfg_to_word(input irq_cfg_t c);
      logic [15:0] w;
      w = '0;
      w[CFG_SRC_LSB +: 3] = c.src;
      w[CFG_INV_BIT]      = c.inv;
      w[CFG_LEVEL_BIT]    = c.level;
      w[CFG_EN_BIT]       = c.en;
      w[CFG_IPL_LSB +: 3] = c.ipl;
      return w;
   endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// irq_sync_edge: synchroniser for one asynchronous interrupt source.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   async_in      raw asynchronous source
//   sync_out      source after SYNC_FF flops
//   prev_out      sync_out delayed by one more cycle
// Comparing sync_out with prev_out (after the channel's select/invert)
// gives the edge detection; keeping the delayed copy per source means a
// channel reconfiguration never fabricates an edge on its own.
module irq_sync_edge #(
   parameter int SYNC_FF = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out,
   output logic prev_out
);

   logic [SYNC_FF-1:0] chain;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain    <= '0;
         prev_out <= 1'b0;
      end else begin
         chain    <= {chain[SYNC_FF-2:0], async_in};
         prev_out <= chain[SYNC_FF-1];
      end
   end

   assign sync_out = chain[SYNC_FF-1];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised fx68k interrupt controller.
// Routes NUM_SRC asynchronous sources to NUM_CH channels, each with its own
// source select, invert, edge/level mode, enable and IPL priority, and
// drives the active-low IPL lines of the CPU.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cs, wr[1:0], address  register access; wr = {upper,lower} byte strobes, 00 = read
//   din / dout            write data / combinational read data
//   src[NUM_SRC-1:0]      raw asynchronous interrupt sources
//   ack                   one-cycle IACK pulse
//   ipl_n[2:0]            active-low IPL to the CPU
//   ticks[31:0]           timestamp input (only used with IRQ_TIMESTAMP_EN)
//   fsm_state             current arbitration state, for observation
// Macro IRQ_TIMESTAMP_EN adds per-channel 32-bit timestamps at 0x20+2ch (hi)
// and 0x21+2ch (lo); without it that window reads zero.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_CH  = 3,
   parameter int NUM_SRC = 4,
   parameter int SYNC_FF = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cs,
   input  logic [1:0]         wr,
   input  logic [5:0]         address,
   input  logic [15:0]        din,
   output logic [15:0]        dout,
   input  logic [NUM_SRC-1:0] src,
   input  logic               ack,
   output logic [2:0]         ipl_n,
   input  logic [31:0]        ticks,
   output irq_state_e         fsm_state
);

   irq_cfg_t            cfg [NUM_CH];
   logic [NUM_CH-1:0]   pending;
   logic [NUM_SRC-1:0]  src_sync, src_prev;
   logic [NUM_CH-1:0]   sig, sig_prev, clr;
   logic [NUM_CH-1:0]   w1c_mask;
   logic                wr_any;
   irq_state_e          state, state_nxt;
   logic [2:0]          active_ch, cur_ipl;
   logic                cand_any;
   logic [2:0]          win_ch, win_ipl;
   logic                unused_in;

   assign unused_in = ^{din, ticks};

   genvar g;
   for (g = 0; g < NUM_SRC; g++) begin : g_src
      irq_sync_edge #(.SYNC_FF(SYNC_FF)) u_sync (
         .clk      (clk),
         .reset_n  (reset_n),
         .async_in (src[g]),
         .sync_out (src_sync[g]),
         .prev_out (src_prev[g])
      );
   end

   // SRC=0 and SRC values beyond NUM_SRC select a constant 0 before invert.
   always_comb begin
      sig      = '0;
      sig_prev = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            if (int'(cfg[c].src) == k) begin
               sig[c]      = src_sync[k-1];
               sig_prev[c] = src_prev[k-1];
            end
         end
         sig[c]      = sig[c] ^ cfg[c].inv;
         sig_prev[c] = sig_prev[c] ^ cfg[c].inv;
      end
   end

   assign wr_any   = cs & (|wr);
   assign w1c_mask = (wr_any && wr[0] && address == ADDR_PENDING) ? din[NUM_CH-1:0] : '0;

   // Acknowledge handshake: while ASSERT presents a level on ipl_n, the CPU
   // answers with a single-cycle ack; that ack retires the latched channel
   // (edge mode) and forces one HOLD cycle with ipl_n released. ack seen in
   // any other state has no effect.
   always_comb begin
      clr = w1c_mask;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ack && state == ST_ASSERT && active_ch == 3'(c)) clr[c] = 1'b1;
      end
   end

   // Configuration registers: each byte lane written independently.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) cfg[c] <= '0;
      end else if (wr_any) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (address == 6'(c)) begin
               if (wr[0]) begin
                  cfg[c].src   <= din[CFG_SRC_LSB +: 3];
                  cfg[c].inv   <= din[CFG_INV_BIT];
                  cfg[c].level <= din[CFG_LEVEL_BIT];
                  cfg[c].en    <= din[CFG_EN_BIT];
               end
               if (wr[1]) cfg[c].ipl <= din[CFG_IPL_LSB +: 3];
            end
         end
      end
   end

   // Pending: level channels mirror the signal; edge channels latch a rising
   // edge, and a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (cfg[c].level) pending[c] <= sig[c];
            else              pending[c] <= (sig[c] & ~sig_prev[c]) | (pending[c] & ~clr[c]);
         end
      end
   end

`ifdef IRQ_TIMESTAMP_EN
   logic [31:0] ts [NUM_CH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) ts[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!cfg[c].level && sig[c] && !sig_prev[c] && !pending[c]) ts[c] <= ticks;
         end
      end
   end
`endif

   // Highest IPL wins; strict '>' keeps the lowest channel on a tie.
   always_comb begin
      cand_any = 1'b0;
      win_ch   = '0;
      win_ipl  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (pending[c] && cfg[c].en && cfg[c].ipl > win_ipl) begin
            cand_any = 1'b1;
            win_ch   = 3'(c);
            win_ipl  = cfg[c].ipl;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (cand_any) state_nxt = ST_ASSERT;
         ST_ASSERT: begin
            if (ack)            state_nxt = ST_HOLD;
            else if (!cand_any) state_nxt = ST_IDLE;
         end
         ST_HOLD:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // cur_ipl is the level on the bus; it is frozen for the whole ASSERT so a
   // later higher-priority arrival waits for re-arbitration after HOLD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         active_ch <= '0;
         cur_ipl   <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && state_nxt == ST_ASSERT) begin
            active_ch <= win_ch;
            cur_ipl   <= win_ipl;
         end else if (state_nxt != ST_ASSERT) begin
            cur_ipl <= '0;
         end
      end
   end

   assign ipl_n     = ~cur_ipl;
   assign fsm_state = state;

   always_comb begin
      dout = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (address == 6'(c)) dout = cfg_to_word(cfg[c]);
      end
      if (address == ADDR_PENDING) dout[NUM_CH-1:0] = pending;
      if (address == ADDR_STATUS)  dout = {8'h00, 1'b0, active_ch, 1'b0, cur_ipl};
`ifdef IRQ_TIMESTAMP_EN
      for (int c = 0; c < NUM_CH; c++) begin
         if (address == ADDR_TS_BASE + 6'(2*c))     dout = ts[c][31:16];
         if (address == ADDR_TS_BASE + 6'(2*c + 1)) dout = ts[c][15:0];
      end
`endif
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then a
// randomized phase; a behavioural model tracks sources through a delay line,
// pending bits and the presented IPL, and one process compares ipl_n,
// fsm_state and dout against it every cycle.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   localparam int NUM_CH  = 3;
   localparam int NUM_SRC = 4;
   localparam int SYNC_FF = 2;

   logic               clk = 1'b0;
   logic               reset_n = 1'b1;
   logic               cs = 1'b0;
   logic [1:0]         wr = 2'b00;
   logic [5:0]         address = '0;
   logic [15:0]        din = '0;
   logic [15:0]        dout;
   logic [NUM_SRC-1:0] src = '0;
   logic               ack = 1'b0;
   logic [2:0]         ipl_n;
   logic [31:0]        ticks = '0;
   irq_state_e         fsm_state;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on = 1'b0;

   irq_ctrl #(.NUM_CH(NUM_CH), .NUM_SRC(NUM_SRC), .SYNC_FF(SYNC_FF)) dut (
      .clk(clk), .reset_n(reset_n), .cs(cs), .wr(wr), .address(address),
      .din(din), .dout(dout), .src(src), .ack(ack), .ipl_n(ipl_n),
      .ticks(ticks), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [NUM_SRC-1:0] m_line [SYNC_FF+1];   // m_line[0] = newest src sample
   int m_src [NUM_CH];
   int m_ipl [NUM_CH];
   bit m_inv [NUM_CH];
   bit m_level [NUM_CH];
   bit m_en [NUM_CH];
   bit m_pend [NUM_CH];
   logic [31:0] m_ts [NUM_CH];
   int m_mode;   // 0 idle, 1 presenting, 2 hold
   int m_ch;     // channel last granted
   int m_lvl;    // level on the bus, 0 when none

   task automatic model_reset();
      for (int i = 0; i <= SYNC_FF; i++) m_line[i] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_src[c] = 0; m_ipl[c] = 0; m_inv[c] = 0; m_level[c] = 0;
         m_en[c] = 0; m_pend[c] = 0; m_ts[c] = '0;
      end
      m_mode = 0; m_ch = 0; m_lvl = 0;
   endtask

   function automatic bit line_val(input int c, input int age);
      bit v = 1'b0;
      if (m_src[c] >= 1 && m_src[c] <= NUM_SRC) v = m_line[age][m_src[c]-1];
      return v ^ m_inv[c];
   endfunction

   task automatic model_step();
      bit sig, prv, rise, clr, ack_hit;
      int w_ch, w_lvl, old_ch;
      logic [NUM_CH-1:0] w1c;
      if (!reset_n) return;
      w_ch = 0; w_lvl = 0;
      for (int c = 0; c < NUM_CH; c++)
         if (m_pend[c] && m_en[c] && m_ipl[c] > w_lvl) begin w_lvl = m_ipl[c]; w_ch = c; end
      ack_hit = ack && (m_mode == 1);
      old_ch  = m_ch;
      case (m_mode)
         0: if (w_lvl > 0) begin m_mode = 1; m_ch = w_ch; m_lvl = w_lvl; end
         1: if (ack) begin m_mode = 2; m_lvl = 0; end
            else if (w_lvl == 0) begin m_mode = 0; m_lvl = 0; end
         default: begin m_mode = 0; m_lvl = 0; end
      endcase
      w1c = (cs && wr[0] && address == 6'h10) ? din[NUM_CH-1:0] : '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sig = line_val(c, SYNC_FF-1);
         prv = line_val(c, SYNC_FF);
         if (m_level[c]) m_pend[c] = sig;
         else begin
            rise = sig && !prv;
            clr  = w1c[c] || (ack_hit && c == old_ch);
            if (rise && !m_pend[c]) m_ts[c] = ticks;
            m_pend[c] = rise || (m_pend[c] && !clr);
         end
      end
      if (cs && wr != 2'b00 && address < NUM_CH) begin
         if (wr[0]) begin
            m_src[address] = int'(din[2:0]); m_inv[address] = din[3];
            m_level[address] = din[4]; m_en[address] = din[5];
         end
         if (wr[1]) m_ipl[address] = int'(din[10:8]);
      end
      for (int i = SYNC_FF; i > 0; i--) m_line[i] = m_line[i-1];
      m_line[0] = src;
   endtask

   function automatic logic [15:0] model_read(input logic [5:0] a);
      int idx;
      if (a < NUM_CH)
         return 16'(m_ipl[a] * 256 + m_en[a] * 32 + m_level[a] * 16 + m_inv[a] * 8 + m_src[a]);
      if (a == 6'h10) begin
         idx = 0;
         for (int c = 0; c < NUM_CH; c++) idx += m_pend[c] << c;
         return 16'(idx);
      end
      if (a == 6'h11) return 16'(m_ch * 16 + m_lvl);
`ifdef IRQ_TIMESTAMP_EN
      if (a >= 6'h20 && a <= 6'h2F) begin
         idx = (int'(a) - 32) / 2;
         if (idx < NUM_CH) return a[0] ? m_ts[idx][15:0] : m_ts[idx][31:16];
      end
`endif
      return 16'h0000;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("ipl_n", 32'(ipl_n), 32'(7 - m_lvl));
         check("fsm_state", 32'(fsm_state), 32'(m_mode));
         check("dout", 32'(dout), 32'(model_read(address)));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wr_reg(input logic [5:0] a, input logic [15:0] d, input logic [1:0] s);
      cs = 1'b1; wr = s; address = a; din = d;
      tick();
      cs = 1'b0; wr = 2'b00;
   endtask

   task automatic rd(input logic [5:0] a, output logic [15:0] v);
      address = a;
      @(negedge clk);
      v = dout;
      #1;
   endtask

   task automatic ack_pulse();
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic wait_ipl(input logic [2:0] exp, input int budget, input string name);
      for (int i = 0; i < budget && ipl_n != exp; i++) tick();
      check(name, 32'(ipl_n), 32'(exp));
   endtask

   task automatic do_reset();
      reset_n = 1'b0; model_reset();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      model_reset();
      #1 reset_n = 1'b0;
      chk_on = 1'b1;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // reset state
      check("rst_ipl_n", 32'(ipl_n), 32'h7);
      rd(6'h10, v); check("rst_pending", 32'(v), 32'h0);
      rd(6'h11, v); check("rst_status", 32'(v), 32'h0);
      rd(6'h00, v); check("rst_cfg0", 32'(v), 32'h0);

      // 1: single edge interrupt and ack
      wr_reg(6'h00, 16'h0121, 2'b11);
      rd(6'h00, v); check("t1_cfg0", 32'(v), 32'h0121);
      src = 4'b0001; repeat (3) tick(); src = 4'b0000;
      wait_ipl(3'b110, SYNC_FF, "t1_ipl_assert");
      rd(6'h10, v); check("t1_pending", 32'(v), 32'h1);
      rd(6'h11, v); check("t1_status", 32'(v), 32'h01);
      ack_pulse();
      check("t1_ipl_after_ack", 32'(ipl_n), 32'h7);
      rd(6'h10, v); check("t1_pending_cleared", 32'(v), 32'h0);

      // 2: two channels at once, higher IPL first
      wr_reg(6'h02, 16'h0323, 2'b11);
      src = 4'b0101; repeat (3) tick(); src = 4'b0000;
      wait_ipl(3'b100, 3, "t2_ipl_ch2");
      rd(6'h11, v); check("t2_status", 32'(v), 32'h23);
      ack_pulse();
      wait_ipl(3'b110, 4, "t2_ipl_ch0");
      rd(6'h11, v); check("t2_status_ch0", 32'(v), 32'h01);
      ack_pulse();
      rd(6'h10, v); check("t2_pending", 32'(v), 32'h0);

      // 3: level mode ignores W1C while the signal is high
      wr_reg(6'h01, 16'h0232, 2'b11);
      src = 4'b0010; repeat (SYNC_FF + 3) tick();
      wr_reg(6'h10, 16'h0002, 2'b01);
      rd(6'h10, v); check("t3_pending_held", 32'(v), 32'h2);
      src = 4'b0000; repeat (SYNC_FF + 3) tick();
      rd(6'h10, v); check("t3_pending_low", 32'(v), 32'h0);
      check("t3_ipl", 32'(ipl_n), 32'h7);
      wr_reg(6'h01, 16'h0000, 2'b11);

      // 4: edge set and W1C on the same cycle; set wins (channel disabled)
      wr_reg(6'h00, 16'h0101, 2'b11);
      src = 4'b0001; repeat (SYNC_FF) tick();
      wr_reg(6'h10, 16'h0001, 2'b01);
      src = 4'b0000;
      rd(6'h10, v); check("t4_set_wins", 32'(v), 32'h1);

      // 5: disabled channel stays pending; enabling asserts two cycles later
      tick();
      check("t5_masked", 32'(ipl_n), 32'h7);
      wr_reg(6'h00, 16'h0021, 2'b01);
      check("t5_ipl_cyc1", 32'(ipl_n), 32'h7);
      tick();
      check("t5_ipl_cyc2", 32'(ipl_n), 32'h6);

      // 6: asynchronous reset while asserting
      reset_n = 1'b0; model_reset();
      #1 check("t6_reset_async", 32'(ipl_n), 32'h7);
      repeat (2) tick();
      reset_n = 1'b1; tick();
      rd(6'h10, v); check("t6_pending", 32'(v), 32'h0);
      rd(6'h00, v); check("t6_cfg0", 32'(v), 32'h0);
`ifdef IRQ_TIMESTAMP_EN
      wr_reg(6'h00, 16'h0121, 2'b11);
      ticks = 32'h12345678;
      src = 4'b0001; repeat (SYNC_FF + 2) tick(); src = 4'b0000;
      ticks = 32'h0;
      rd(6'h20, v); check("t6_ts_hi", 32'(v), 32'h1234);
      rd(6'h21, v); check("t6_ts_lo", 32'(v), 32'h5678);
`else
      rd(6'h20, v); check("t6_ts_hi_absent", 32'(v), 32'h0);
      rd(6'h21, v); check("t6_ts_lo_absent", 32'(v), 32'h0);
`endif

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         cs = 1'b0; wr = 2'b00; ack = 1'b0;
         if (i == 1500) do_reset();
         if ($urandom_range(0, 99) < 15) begin
            cs = 1'b1;
            wr = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 5))
               0, 1, 2: address = 6'($urandom_range(0, NUM_CH - 1));
               3:       address = 6'h10;
               default: address = 6'($urandom_range(0, 63));
            endcase
            din = 16'($urandom);
         end else begin
            address = 6'($urandom_range(0, 63));
         end
         if ($urandom_range(0, 9) == 0) ack = 1'b1;
         if ($urandom_range(0, 3) == 0) src = 4'($urandom);
         ticks = $urandom;
         tick();
      end
      cs = 1'b0; wr = 2'b00; ack = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
